// File: rtl/jk_bank_pkg.sv
// ---------------------------------------------------------------------------
// jk_bank_pkg
// Shared definitions for the multi-mode flip-flop bank.
//   MODE_JK / MODE_SR / MODE_T / MODE_D : encodings of the 2-bit mode input
//   sat_inc(cnt, maxVal)               : saturating increment helper
// ---------------------------------------------------------------------------
package jk_bank_pkg;

    localparam logic [1:0] MODE_JK = 2'b00;
    localparam logic [1:0] MODE_SR = 2'b01;
    localparam logic [1:0] MODE_T  = 2'b10;
    localparam logic [1:0] MODE_D  = 2'b11;

    // Increment that sticks at maxVal instead of wrapping. Works on a 32-bit
    // carrier so any counter up to 32 bits wide can share it; the caller
    // passes its own all-ones value as the ceiling.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                            input logic [31:0] maxVal);
        if (cnt >= maxVal) begin
            return maxVal;
        end
        return cnt + 32'd1;
    endfunction

endpackage

// File: rtl/jk_cell.sv
// ---------------------------------------------------------------------------
// jk_cell
// Combinational next-state logic for one bit of the flip-flop bank.
// Ports:
//   mode    in  2  JK / SR / T / D selection
//   j       in  1  J, S, T or D input depending on mode
//   k       in  1  K or R input (unused in T and D modes)
//   q       in  1  current state of the bit
//   qNext   out 1  state the bit should take if the bank is enabled
//   illegal out 1  high when SR mode sees S and R both asserted
// ---------------------------------------------------------------------------
module jk_cell
    import jk_bank_pkg::*;
(
    input  logic [1:0] mode,
    input  logic       j,
    input  logic       k,
    input  logic       q,
    output logic       qNext,
    output logic       illegal
);

    // Decode the per-mode truth tables. Every path starts from "hold" so a
    // forbidden SR pair simply leaves the bit alone while flagging it.
    always_comb begin
        qNext   = q;
        illegal = 1'b0;
        case (mode)
            MODE_JK: begin
                case ({j, k})
                    2'b01:   qNext = 1'b0;
                    2'b10:   qNext = 1'b1;
                    2'b11:   qNext = ~q;
                    default: qNext = q;
                endcase
            end
            MODE_SR: begin
                case ({j, k})
                    2'b01:   qNext = 1'b0;
                    2'b10:   qNext = 1'b1;
                    2'b11: begin
                        qNext   = q;
                        illegal = 1'b1;
                    end
                    default: qNext = q;
                endcase
            end
            MODE_T: begin
                qNext = j ? ~q : q;
            end
            default: begin
                qNext = j;
            end
        endcase
    end

endmodule

// File: rtl/jk_ff_bank.sv
// ---------------------------------------------------------------------------
// jk_ff_bank
// WIDTH-bit bank of flip-flops sharing one run-time mode (JK, SR, T or D),
// with parallel load, clock enable, per-bit change mask, sticky SR error flag
// and a saturating counter of edges on which the state changed.
// Ports:
//   clk        in   1      rising-edge clock
//   reset      in   1      synchronous, active-low reset
//   en         in   1      update enable (q holds when low)
//   mode       in   2      00=JK 01=SR 10=T 11=D
//   j          in   WIDTH  J / S / T / D per bit
//   k          in   WIDTH  K / R per bit
//   load       in   1      parallel load, overrides en and mode
//   load_data  in   WIDTH  value loaded when load=1
//   err_clr    in   1      clears the sticky error flag
//   q          out  WIDTH  registered state
//   qn         out  WIDTH  inverse of q
//   changed    out  WIDTH  bits that changed on the previous edge
//   err        out  1      sticky illegal-SR flag
//   chg_cnt    out  CNT_W  saturating count of edges where q changed
// ---------------------------------------------------------------------------
module jk_ff_bank
    import jk_bank_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] changed,
    output logic             err,
    output logic [CNT_W-1:0] chg_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] state_q;
    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] changed_q;
    logic [CNT_W-1:0] chgCnt_q;
    logic [CNT_W-1:0] chgCnt_d;
    logic             err_q;

    logic [WIDTH-1:0] cellNext;
    logic [WIDTH-1:0] cellIllegal;
    logic [WIDTH-1:0] chgMask;
    logic             illegalSeen;

    // One combinational cell per bit computes what that bit would become if
    // the bank were enabled this cycle.
    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        jk_cell uCell (
            .mode    (mode),
            .j       (j[i]),
            .k       (k[i]),
            .q       (state_q[i]),
            .qNext   (cellNext[i]),
            .illegal (cellIllegal[i])
        );
    end

    // Priority mux below reset: load beats enable, enable beats hold. The
    // change mask and counter work from the real difference, so a load that
    // rewrites the same value counts as no change. The error condition is
    // masked by load so an illegal SR pair under a load is ignored.
    always_comb begin
        state_d = state_q;
        if (load) begin
            state_d = load_data;
        end else if (en) begin
            state_d = cellNext;
        end
        chgMask     = state_d ^ state_q;
        illegalSeen = (mode == MODE_SR) && en && !load && (|cellIllegal);
        chgCnt_d    = chgCnt_q;
        if (|chgMask) begin
            chgCnt_d = CNT_W'(sat_inc(32'(chgCnt_q), 32'(CNT_MAX)));
        end
    end

    // All state registers share the synchronous active-low reset, which
    // overrides everything including a pending load. A new error on the same
    // edge as err_clr wins so a fault is never lost.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= RESET_VAL;
            changed_q <= '0;
            chgCnt_q  <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            changed_q <= chgMask;
            chgCnt_q  <= chgCnt_d;
            if (illegalSeen) begin
                err_q <= 1'b1;
            end else if (err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    assign q       = state_q;
    assign qn      = ~state_q;
    assign changed = changed_q;
    assign err     = err_q;
    assign chg_cnt = chgCnt_q;

endmodule
